// File: rtl/fft_peak_detect.sv
// Finds the largest squared-magnitude bin of one 512-point FFT output frame.
// Three-stage datapath (products, sum, compare) driven by an IDLE/SCAN/DRAIN/DONE FSM.
module fft_peak_detect #(
    parameter int MIN_BIN = 1,
    parameter int MAX_BIN = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               reset_max,
    input  logic               in_valid,
    input  logic [8:0]         in_index,
    input  logic signed [15:0] in_real,
    input  logic signed [15:0] in_imag,
    output logic [8:0]         peak_bin,
    output logic [31:0]        peak_mag,
    output logic               peak_valid,
    output logic               frame_done,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [8:0] MIN_B = 9'(MIN_BIN);
    localparam logic [8:0] MAX_B = 9'(MAX_BIN);
    localparam logic [8:0] LAST  = 9'd511;

    state_t      state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic        s1_vld_q, s1_vld_d;
    logic [8:0]  s1_idx_q, s1_idx_d;
    logic [31:0] s1_pr_q, s1_pr_d;
    logic [31:0] s1_pi_q, s1_pi_d;
    logic        s2_vld_q, s2_vld_d;
    logic [8:0]  s2_idx_q, s2_idx_d;
    logic [31:0] s2_mag_q, s2_mag_d;
    logic [8:0]  max_bin_q, max_bin_d;
    logic [31:0] max_mag_q, max_mag_d;
    logic [8:0]  peak_bin_q, peak_bin_d;
    logic [31:0] peak_mag_q, peak_mag_d;
    logic        peak_valid_q, peak_valid_d;
    logic        frame_done_q, frame_done_d;

    logic signed [31:0] re_x, im_x;
    logic               accept;
    logic               eligible;

    assign re_x = 32'(in_real);
    assign im_x = 32'(in_imag);

    assign eligible = s2_vld_q && (s2_idx_q >= MIN_B) && (s2_idx_q <= MAX_B);

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        accept       = 1'b0;
        s1_vld_d     = 1'b0;
        s1_idx_d     = s1_idx_q;
        s1_pr_d      = s1_pr_q;
        s1_pi_d      = s1_pi_q;
        s2_vld_d     = s1_vld_q;
        s2_idx_d     = s1_idx_q;
        s2_mag_d     = s1_pr_q + s1_pi_q;
        max_bin_d    = max_bin_q;
        max_mag_d    = max_mag_q;
        peak_bin_d   = peak_bin_q;
        peak_mag_d   = peak_mag_q;
        peak_valid_d = peak_valid_q;
        frame_done_d = 1'b0;

        // Strictly-greater compare keeps the earliest index on ties
        if (eligible && (s2_mag_q > max_mag_q)) begin
            max_bin_d = s2_idx_q;
            max_mag_d = s2_mag_q;
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid && (in_index == 9'd0)) begin
                    accept    = 1'b1;
                    max_bin_d = MIN_B;
                    max_mag_d = 32'd0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (in_index == LAST) begin
                        drain_cnt_d = 2'd0;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + 2'd1;
                if (drain_cnt_q == 2'd2) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                peak_bin_d   = max_bin_q;
                peak_mag_d   = max_mag_q;
                peak_valid_d = 1'b1;
                frame_done_d = 1'b1;
                state_d      = IDLE;
            end
        endcase

        if (accept) begin
            s1_vld_d = 1'b1;
            s1_idx_d = in_index;
            s1_pr_d  = re_x * re_x;
            s1_pi_d  = im_x * im_x;
        end

        if (reset_max) begin
            state_d      = IDLE;
            drain_cnt_d  = 2'd0;
            s1_vld_d     = 1'b0;
            s2_vld_d     = 1'b0;
            max_bin_d    = 9'd0;
            max_mag_d    = 32'd0;
            peak_bin_d   = 9'd0;
            peak_mag_d   = 32'd0;
            peak_valid_d = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            drain_cnt_q  <= 2'd0;
            s1_vld_q     <= 1'b0;
            s1_idx_q     <= 9'd0;
            s1_pr_q      <= 32'd0;
            s1_pi_q      <= 32'd0;
            s2_vld_q     <= 1'b0;
            s2_idx_q     <= 9'd0;
            s2_mag_q     <= 32'd0;
            max_bin_q    <= 9'd0;
            max_mag_q    <= 32'd0;
            peak_bin_q   <= 9'd0;
            peak_mag_q   <= 32'd0;
            peak_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            s1_vld_q     <= s1_vld_d;
            s1_idx_q     <= s1_idx_d;
            s1_pr_q      <= s1_pr_d;
            s1_pi_q      <= s1_pi_d;
            s2_vld_q     <= s2_vld_d;
            s2_idx_q     <= s2_idx_d;
            s2_mag_q     <= s2_mag_d;
            max_bin_q    <= max_bin_d;
            max_mag_q    <= max_mag_d;
            peak_bin_q   <= peak_bin_d;
            peak_mag_q   <= peak_mag_d;
            peak_valid_q <= peak_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign peak_bin   = peak_bin_q;
    assign peak_mag   = peak_mag_q;
    assign peak_valid = peak_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == SCAN) || (state_q == DRAIN);

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect.
// Randomized frames compared against a plain-arithmetic peak model.
module tb_fft_peak_detect;

    localparam int MIN_BIN = 1;
    localparam int MAX_BIN = 255;

    logic               clk = 1'b0;
    logic               reset;
    logic               reset_max;
    logic               in_valid;
    logic [8:0]         in_index;
    logic signed [15:0] in_real;
    logic signed [15:0] in_imag;
    logic [8:0]         peak_bin;
    logic [31:0]        peak_mag;
    logic               peak_valid;
    logic               frame_done;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [15:0] fr_re [512];
    logic signed [15:0] fr_im [512];

    fft_peak_detect #(.MIN_BIN(MIN_BIN), .MAX_BIN(MAX_BIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .reset_max  (reset_max),
        .in_valid   (in_valid),
        .in_index   (in_index),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .peak_valid (peak_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_index  = 9'($urandom_range(1, 511));
        in_real   = 16'($urandom);
        in_imag   = 16'($urandom);
        reset_max = 1'b0;
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 512; i++) begin
            fr_re[i] = 16'sd0;
            fr_im[i] = 16'sd0;
        end
    endtask

    task automatic rand_frame(input int lim);
        for (int i = 0; i < 512; i++) begin
            fr_re[i] = 16'($signed($urandom_range(0, 2 * lim)) - lim);
            fr_im[i] = 16'($signed($urandom_range(0, 2 * lim)) - lim);
        end
    endtask

    // Reference: largest re^2+im^2 among eligible bins, earliest bin on ties
    task automatic model(output logic [8:0] b, output logic [31:0] m);
        longint best;
        longint mg;
        int     bb;
        best = 0;
        bb   = MIN_BIN;
        for (int i = 0; i < 512; i++) begin
            mg = longint'(fr_re[i]) * fr_re[i] + longint'(fr_im[i]) * fr_im[i];
            if (i >= MIN_BIN && i <= MAX_BIN && mg > best) begin
                best = mg;
                bb   = i;
            end
        end
        b = 9'(bb);
        m = 32'(best);
    endtask

    task automatic send_beat(input int idx);
        in_valid = 1'b1;
        in_index = 9'(idx);
        in_real  = fr_re[idx];
        in_imag  = fr_im[idx];
        tick();
    endtask

    // Sends beats 0..511, optional 3-cycle gap after beat gap_after,
    // then records when frame_done appears and what the outputs hold.
    task automatic run_frame(input int gap_after, output int lat,
                             output logic [8:0] b, output logic [31:0] m,
                             output logic v, output int width);
        for (int i = 0; i < 512; i++) begin
            send_beat(i);
            if (i == gap_after) begin
                for (int g = 0; g < 3; g++) begin
                    idle_inputs();
                    tick();
                end
            end
        end
        idle_inputs();
        lat   = -1;
        width = 0;
        b     = 'x;
        m     = 'x;
        v     = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (frame_done === 1'b1) begin
                if (lat < 0) begin
                    lat = c;
                    b   = peak_bin;
                    m   = peak_mag;
                    v   = peak_valid;
                end
                width++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        #2;
        n_tests++;
        if ({peak_bin, peak_mag, peak_valid, frame_done, busy} !== 44'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bin=%0d mag=%0d v=%b fd=%b busy=%b want all 0",
                     peak_bin, peak_mag, peak_valid, frame_done, busy);
        end
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_peak();
        int lat, w;
        logic [8:0] b;
        logic [31:0] m;
        logic v;
        clear_frame();
        fr_re[37] = 16'sd1000;
        run_frame(-1, lat, b, m, v, w);
        n_tests++;
        if (lat !== 4 || w !== 1) begin
            n_fail++;
            $display("FAIL single_latency: got lat=%0d width=%0d want lat=4 width=1", lat, w);
        end
        n_tests++;
        if (b !== 9'd37 || m !== 32'd1000000 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL single_peak: got bin=%0d mag=%0d v=%b want 37 1000000 1", b, m, v);
        end
        n_tests++;
        if (busy !== 1'b0 || peak_valid !== 1'b1 || peak_bin !== 9'd37) begin
            n_fail++;
            $display("FAIL single_hold: got busy=%b v=%b bin=%0d want 0 1 37",
                     busy, peak_valid, peak_bin);
        end
    endtask

    task automatic test_tie();
        int lat, w;
        logic [8:0] b;
        logic [31:0] m;
        logic v;
        rand_frame(200);
        fr_re[20] = -16'sd300;
        fr_im[20] = 16'sd400;
        fr_re[30] = -16'sd300;
        fr_im[30] = 16'sd400;
        run_frame(-1, lat, b, m, v, w);
        n_tests++;
        if (lat !== 4 || b !== 9'd20 || m !== 32'd250000) begin
            n_fail++;
            $display("FAIL tie_lowest: got lat=%0d bin=%0d mag=%0d want 4 20 250000", lat, b, m);
        end
    endtask

    task automatic test_excluded_bins();
        int lat, w;
        logic [8:0] b;
        logic [31:0] m;
        logic v;
        clear_frame();
        fr_re[0]   = 16'sd32767;
        fr_re[300] = -16'sd32768;
        fr_im[300] = -16'sd32768;
        fr_re[5]   = 16'sd10;
        fr_im[5]   = 16'sd10;
        run_frame(-1, lat, b, m, v, w);
        n_tests++;
        if (lat !== 4 || b !== 9'd5 || m !== 32'd200) begin
            n_fail++;
            $display("FAIL excluded_bins: got lat=%0d bin=%0d mag=%0d want 4 5 200", lat, b, m);
        end
    endtask

    task automatic test_random_frames();
        int lat, w;
        logic [8:0] b, eb;
        logic [31:0] m, em;
        logic v;
        for (int f = 0; f < 4; f++) begin
            rand_frame(f[0] ? 32768 : 1000);
            if (f == 3) begin
                fr_re[255] = -16'sd32768;
                fr_im[255] = -16'sd32768;
            end
            model(eb, em);
            run_frame(-1, lat, b, m, v, w);
            n_tests++;
            if (lat !== 4 || b !== eb || m !== em || v !== 1'b1) begin
                n_fail++;
                $display("FAIL random_frame%0d: got lat=%0d bin=%0d mag=%0d v=%b want 4 %0d %0d 1",
                         f, lat, b, m, v, eb, em);
            end
        end
        for (int c = 0; c < 10; c++) tick();
        n_tests++;
        if (peak_bin !== eb || peak_mag !== em || peak_valid !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL result_hold: got bin=%0d mag=%0d v=%b fd=%b want %0d %0d 1 0",
                     peak_bin, peak_mag, peak_valid, frame_done, eb, em);
        end
    endtask

    task automatic test_reset_max();
        int lat, w;
        int seen;
        logic [8:0] b, eb;
        logic [31:0] m, em;
        logic v;
        rand_frame(5000);
        for (int i = 0; i < 200; i++) send_beat(i);
        reset_max = 1'b1;
        send_beat(200);
        reset_max = 1'b0;
        n_tests++;
        if (peak_valid !== 1'b0 || peak_mag !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_max_clear: got v=%b mag=%0d busy=%b want 0 0 0",
                     peak_valid, peak_mag, busy);
        end
        seen = 0;
        for (int i = 201; i < 512; i++) begin
            send_beat(i);
            if (frame_done === 1'b1) seen++;
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            tick();
            if (frame_done === 1'b1) seen++;
        end
        n_tests++;
        if (seen !== 0 || peak_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_max_discard: got frame_done count=%0d v=%b want 0 0",
                     seen, peak_valid);
        end
        rand_frame(5000);
        model(eb, em);
        run_frame(-1, lat, b, m, v, w);
        n_tests++;
        if (lat !== 4 || b !== eb || m !== em || v !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_max_next: got lat=%0d bin=%0d mag=%0d v=%b want 4 %0d %0d 1",
                     lat, b, m, v, eb, em);
        end
    endtask

    task automatic test_gaps_preframe();
        int lat, w;
        logic [8:0] b, eb;
        logic [31:0] m, em;
        logic v;
        rand_frame(3000);
        model(eb, em);
        for (int i = 10; i <= 50; i++) begin
            in_valid = 1'b1;
            in_index = 9'(i);
            in_real  = 16'sd32767;
            in_imag  = 16'sd32767;
            tick();
        end
        run_frame(100, lat, b, m, v, w);
        n_tests++;
        if (lat !== 4 || b !== eb || m !== em || v !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_preframe: got lat=%0d bin=%0d mag=%0d v=%b want 4 %0d %0d 1",
                     lat, b, m, v, eb, em);
        end
    endtask

    task automatic test_async_reset();
        int lat, w;
        logic [8:0] b;
        logic [31:0] m;
        logic v;
        rand_frame(3000);
        for (int i = 0; i < 150; i++) send_beat(i);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({peak_bin, peak_mag, peak_valid, frame_done, busy} !== 44'd0) begin
            n_fail++;
            $display("FAIL async_reset: got bin=%0d mag=%0d v=%b fd=%b busy=%b want all 0",
                     peak_bin, peak_mag, peak_valid, frame_done, busy);
        end
        idle_inputs();
        tick();
        tick();
        #2;
        reset = 1'b0;
        tick();
        clear_frame();
        run_frame(-1, lat, b, m, v, w);
        n_tests++;
        if (lat !== 4 || b !== 9'd1 || m !== 32'd0 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_zero_frame: got lat=%0d bin=%0d mag=%0d v=%b want 4 1 0 1",
                     lat, b, m, v);
        end
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_tie();
        test_excluded_bins();
        test_random_frames();
        test_reset_max();
        test_gaps_preframe();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter MIN_BIN, default 1, lowest bin index eligible for peak (excludes DC).
REQ-002 SHALL have parameter MAX_BIN, default 255, highest bin index eligible (first half of the 512-point frame).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port reset_max  in  1  synchronous clear from the FFT controller; high while the controller waits for samples.
REQ-006 SHALL have port in_valid  in  1  FFT output beat valid (high during the controller's output phase).
REQ-007 SHALL have port in_index  in  9  bin index of current beat (0..511).
REQ-008 SHALL have port in_real  in  16  signed real part of the bin.
REQ-009 SHALL have port in_imag  in  16  signed imaginary part of the bin.
REQ-010 SHALL have port peak_bin  out  9  bin index of the frame maximum.
REQ-011 SHALL have port peak_mag  out  32  unsigned squared magnitude of that bin.
REQ-012 SHALL have port peak_valid  out  1  level; peak_bin/peak_mag hold a completed frame result.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse when a new result is latched.
REQ-014 SHALL have port busy  out  1  high in SCAN and DRAIN.

Function
REQ-015 SHALL compute mag = in_real*in_real + in_imag*in_imag as 32-bit unsigned; max value 2^31, no overflow, no saturation.
REQ-016 SHALL pipeline the magnitude: stage 1 registers the two products, index and valid; stage 2 registers the sum, index and valid; stage 3 performs the compare/update.
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, DONE.
REQ-018 IDLE: an in_valid beat with in_index==0 enters the pipeline and moves to SCAN; running max cleared to mag 0, bin MIN_BIN; beats with nonzero index are dropped (partial frame).
REQ-019 SCAN: every in_valid beat enters the pipeline; in_valid low stalls nothing and inserts a bubble; a beat with in_index==511 moves to DRAIN.
REQ-020 SHALL ignore in_valid while in DRAIN or DONE.
REQ-021 DRAIN: lasts until the 511 beat has passed stage 3 (2 cycles), then moves to DONE.
REQ-022 DONE: for one cycle, copies the running max to peak_bin/peak_mag, pulses frame_done, sets peak_valid, then returns to IDLE.
REQ-023 frame_done SHALL assert exactly 4 cycles after the edge that samples the index-511 beat.
REQ-024 Stage 3 SHALL update the running max only if MIN_BIN <= index <= MAX_BIN and mag is strictly greater than the running max; ties keep the lowest index.
REQ-025 If every eligible magnitude is 0, the result SHALL be peak_bin=MIN_BIN, peak_mag=0.
REQ-026 peak_valid/peak_bin/peak_mag SHALL hold between frames until the next DONE or reset_max.
REQ-027 reset_max SHALL take priority over all other inputs: state to IDLE; pipeline valids, running max, peak_bin, peak_mag and peak_valid cleared; frame_done low; a same-cycle index-0 beat is dropped.
REQ-028 reset_max asserted mid-frame SHALL discard the partial frame; no frame_done.
REQ-029 Out-of-order indices SHALL be processed as given; only in_index==511 ends a frame.

Reset
REQ-030 While reset is high, state SHALL be IDLE and all outputs and pipeline registers SHALL be 0, independent of clk.
REQ-031 After reset deasserts, the block SHALL accept a frame starting on the next index-0 beat.

Verification
REQ-032 Scenario: full frame with bin 37 = (1000,0) and all other bins 0 -> frame_done 4 cycles after beat 511; peak_bin=37, peak_mag=1000000; peak_valid=1.
REQ-033 Scenario: bins 20 and 30 both (-300,400), all others smaller -> peak_bin=20, peak_mag=250000.
REQ-034 Scenario: bin 0 = (32767,0), bin 300 = (-32768,-32768), bin 5 = (10,10), all others 0 -> peak_bin=5, peak_mag=200.
REQ-035 Scenario: reset_max pulsed at beat 200 of a frame -> no frame_done; peak_valid=0; next full frame is processed normally.
REQ-036 Scenario: frame with in_valid dropped for 3 cycles after beat 100, and beats 10..50 sent before the first index-0 beat -> pre-frame beats ignored; result same as with an unbroken frame.
REQ-037 Scenario: reset asserted asynchronously mid-SCAN -> outputs 0 immediately; all-zero frame afterwards -> peak_bin=1, peak_mag=0.
